// File: rtl/tlc_pkg.sv
// Shared types for the traffic-light monitor: lamp codes, monitor states and fault causes.
package tlc_pkg;

  // Two-bit lamp code as driven by the signal heads.
  typedef enum logic [1:0] {
    OFF    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10,
    RED    = 2'b11
  } light_e;

  typedef enum logic [1:0] {
    MON_INIT  = 2'b00,
    MON_ARMED = 2'b01,
    MON_FAULT = 2'b10
  } mon_state_e;

  // Numeric value doubles as priority: the lowest non-zero code wins.
  typedef enum logic [2:0] {
    NONE          = 3'd0,
    INVALID       = 3'd1,
    CONFLICT      = 3'd2,
    ILLEGAL_TRANS = 3'd3,
    SHORT_YELLOW  = 3'd4,
    WATCHDOG      = 3'd5
  } fault_e;

  localparam int unsigned NumLamps = 3;

  // Saturating 8-bit increment shared by the yellow and all-red counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? 8'hFF : val + 8'd1;
  endfunction

endpackage

// File: rtl/lamp_tracker.sv
// Per-lamp history: previous code plus yellow-duration counter, and the
// per-lamp violation flags derived from the current code against that history.
module lamp_tracker
  import tlc_pkg::*;
#(
  parameter int unsigned YEL_MIN = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] code,
  output logic       invalid,
  output logic       illegal,
  output logic       short_yellow
);

  light_e     cur;
  light_e     prev_q;
  logic [7:0] yel_cnt_q;
  logic [7:0] yel_cnt_d;

  assign cur = light_e'(code);

  // Yellow counter: 1 on the first yellow cycle, then count up, cleared otherwise.
  always_comb begin
    yel_cnt_d = '0;
    if (cur == YELLOW) begin
      yel_cnt_d = (prev_q == YELLOW) ? sat_inc8(yel_cnt_q) : 8'd1;
    end
  end

  // History is tracked in every monitor state so re-arming starts from fresh context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= RED;
      yel_cnt_q <= '0;
    end else begin
      prev_q    <= cur;
      yel_cnt_q <= yel_cnt_d;
    end
  end

  // Flags compare this cycle's code with last cycle's; yel_cnt_q is the yellow length so far.
  always_comb begin
    invalid      = (cur == OFF);
    illegal      = ((prev_q == GREEN)  && (cur == RED))    ||
                   ((prev_q == RED)    && (cur == YELLOW)) ||
                   ((prev_q == YELLOW) && (cur == GREEN));
    short_yellow = (prev_q == YELLOW) && (cur == RED) && (yel_cnt_q < 8'(YEL_MIN));
  end

endmodule

// File: rtl/light_monitor.sv
// Traffic-light conflict monitor for one intersection (L1 NB 4th Ave, L2/L3 Harrison St).
// Latches the highest-priority violation and holds it until Clear.
// Optional all-red watchdog enabled by defining LIGHT_MONITOR_WATCHDOG_EN.
module light_monitor
  import tlc_pkg::*;
#(
  parameter int unsigned YEL_MIN    = 5,
  parameter int unsigned ALLRED_MAX = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] L1,
  input  logic [1:0] L2,
  input  logic [1:0] L3,
  input  logic       Clear,
  output logic       Fault,
  output logic [2:0] FaultCode,
  output logic [2:0] FaultLamp
);

  logic [NumLamps-1:0] invalid;
  logic [NumLamps-1:0] illegal;
  logic [NumLamps-1:0] short_yel;
  logic [NumLamps-1:0] conflict_lamps;
  logic                watchdog_hit;

  fault_e              viol_code;
  logic [NumLamps-1:0] viol_lamps;

  mon_state_e          state_q, state_d;
  logic                fault_q, fault_d;
  fault_e              code_q, code_d;
  logic [NumLamps-1:0] lamp_q, lamp_d;

  lamp_tracker #(.YEL_MIN(YEL_MIN)) u_lamp1 (
    .clk          (Clock),
    .rst_n        (Reset),
    .code         (L1),
    .invalid      (invalid[0]),
    .illegal      (illegal[0]),
    .short_yellow (short_yel[0])
  );

  lamp_tracker #(.YEL_MIN(YEL_MIN)) u_lamp2 (
    .clk          (Clock),
    .rst_n        (Reset),
    .code         (L2),
    .invalid      (invalid[1]),
    .illegal      (illegal[1]),
    .short_yellow (short_yel[1])
  );

  lamp_tracker #(.YEL_MIN(YEL_MIN)) u_lamp3 (
    .clk          (Clock),
    .rst_n        (Reset),
    .code         (L3),
    .invalid      (invalid[2]),
    .illegal      (illegal[2]),
    .short_yellow (short_yel[2])
  );

  // Cross-street conflict: 4th Ave showing anything but red while a Harrison head is non-red.
  always_comb begin
    conflict_lamps = '0;
    if ((L1 != RED) && ((L2 != RED) || (L3 != RED))) begin
      conflict_lamps = {(L3 != RED), (L2 != RED), 1'b1};
    end
  end

`ifdef LIGHT_MONITOR_WATCHDOG_EN
  logic [7:0] allred_cnt_q;
  logic [7:0] allred_cnt_d;
  logic       all_red;

  // All-red counter; fires on the cycle whose count would exceed the limit.
  always_comb begin
    all_red      = (L1 == RED) && (L2 == RED) && (L3 == RED);
    allred_cnt_d = all_red ? sat_inc8(allred_cnt_q) : 8'd0;
    watchdog_hit = all_red && (allred_cnt_d > 8'(ALLRED_MAX));
  end

  // All-red counter register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      allred_cnt_q <= '0;
    end else begin
      allred_cnt_q <= allred_cnt_d;
    end
  end
`else
  logic unused_allred_max;
  assign unused_allred_max = ^ALLRED_MAX;
  assign watchdog_hit      = 1'b0;
`endif

  // Priority encode: lowest fault code wins, lamps are those implicated in that code only.
  always_comb begin
    viol_code  = NONE;
    viol_lamps = '0;
    if (|invalid) begin
      viol_code  = INVALID;
      viol_lamps = invalid;
    end else if (|conflict_lamps) begin
      viol_code  = CONFLICT;
      viol_lamps = conflict_lamps;
    end else if (|illegal) begin
      viol_code  = ILLEGAL_TRANS;
      viol_lamps = illegal;
    end else if (|short_yel) begin
      viol_code  = SHORT_YELLOW;
      viol_lamps = short_yel;
    end else if (watchdog_hit) begin
      viol_code  = WATCHDOG;
      viol_lamps = '1;
    end
  end

  // Monitor FSM next state and latched fault outputs.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    code_d  = code_q;
    lamp_d  = lamp_q;
    unique case (state_q)
      MON_INIT: begin
        state_d = MON_ARMED;
      end
      MON_ARMED: begin
        if (viol_code != NONE) begin
          state_d = MON_FAULT;
          fault_d = 1'b1;
          code_d  = viol_code;
          lamp_d  = viol_lamps;
        end
      end
      MON_FAULT: begin
        // Clear takes precedence over anything observed this cycle.
        if (Clear) begin
          state_d = MON_INIT;
          fault_d = 1'b0;
          code_d  = NONE;
          lamp_d  = '0;
        end
      end
      default: begin
        state_d = MON_INIT;
        fault_d = 1'b0;
        code_d  = NONE;
        lamp_d  = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= MON_INIT;
      fault_q <= 1'b0;
      code_q  <= NONE;
      lamp_q  <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      lamp_q  <= lamp_d;
    end
  end

  assign Fault     = fault_q;
  assign FaultCode = code_q;
  assign FaultLamp = lamp_q;

endmodule

// File: tb/tb_light_monitor.sv
// Bench for light_monitor: directed scenarios plus randomized lamp sequences,
// compared every cycle against a run-length based reference model.
module tb_light_monitor;

  localparam int unsigned YelMin    = 5;
  localparam int unsigned AllredMax = 8;
`ifdef LIGHT_MONITOR_WATCHDOG_EN
  localparam bit WdEn     = 1'b1;
  localparam int WdFault  = 1;
  localparam int WdCode   = 5;
`else
  localparam bit WdEn     = 1'b0;
  localparam int WdFault  = 0;
  localparam int WdCode   = 0;
`endif

  localparam logic [1:0] X = 2'b00;
  localparam logic [1:0] G = 2'b01;
  localparam logic [1:0] Y = 2'b10;
  localparam logic [1:0] R = 2'b11;

  logic       Clock;
  logic       Reset;
  logic [1:0] L1, L2, L3;
  logic       Clear;
  logic       Fault;
  logic [2:0] FaultCode;
  logic [2:0] FaultLamp;

  int n_vec;
  int n_err;

  // Reference model: mode 0 init, 1 armed, 2 faulted; history as run lengths.
  int m_mode;
  int m_prev[3];
  int m_yrun[3];
  int m_allred;
  int m_fault;
  int m_code;
  int m_lamp;

  light_monitor #(
    .YEL_MIN    (YelMin),
    .ALLRED_MAX (AllredMax)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .L1        (L1),
    .L2        (L2),
    .L3        (L3),
    .Clear     (Clear),
    .Fault     (Fault),
    .FaultCode (FaultCode),
    .FaultLamp (FaultLamp)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_fault"}, int'(Fault), m_fault);
    check_eq({tag, "_code"}, int'(FaultCode), m_code);
    check_eq({tag, "_lamp"}, int'(FaultLamp), m_lamp);
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_allred = 0;
    m_fault  = 0;
    m_code   = 0;
    m_lamp   = 0;
    for (int i = 0; i < 3; i++) begin
      m_prev[i] = 3;
      m_yrun[i] = 0;
    end
  endtask

  task automatic model_clock(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                             input logic clr);
    int cur[3];
    int vcode, vlamp, iv, il, sy, ar_next, ylen;
    bit all_red;
    cur[0] = int'(a);
    cur[1] = int'(b);
    cur[2] = int'(c);
    all_red = (cur[0] == 3) && (cur[1] == 3) && (cur[2] == 3);
    ar_next = all_red ? ((m_allred >= 255) ? 255 : m_allred + 1) : 0;
    iv = 0; il = 0; sy = 0;
    for (int i = 0; i < 3; i++) begin
      ylen = (m_yrun[i] > 255) ? 255 : m_yrun[i];
      if (cur[i] == 0) iv |= (1 << i);
      if ((m_prev[i] == 1 && cur[i] == 3) || (m_prev[i] == 3 && cur[i] == 2) ||
          (m_prev[i] == 2 && cur[i] == 1)) il |= (1 << i);
      if (m_prev[i] == 2 && cur[i] == 3 && ylen < int'(YelMin)) sy |= (1 << i);
    end
    // Evaluate from the weakest cause up so the lowest code overrides.
    vcode = 0; vlamp = 0;
    if (WdEn && all_red && ar_next > int'(AllredMax)) begin vcode = 5; vlamp = 7; end
    if (sy != 0) begin vcode = 4; vlamp = sy; end
    if (il != 0) begin vcode = 3; vlamp = il; end
    if (cur[0] != 3 && (cur[1] != 3 || cur[2] != 3)) begin
      vcode = 2;
      vlamp = 1 | ((cur[1] != 3) ? 2 : 0) | ((cur[2] != 3) ? 4 : 0);
    end
    if (iv != 0) begin vcode = 1; vlamp = iv; end
    case (m_mode)
      0: m_mode = 1;
      1: if (vcode != 0) begin
        m_mode = 2; m_fault = 1; m_code = vcode; m_lamp = vlamp;
      end
      default: if (clr) begin
        m_mode = 0; m_fault = 0; m_code = 0; m_lamp = 0;
      end
    endcase
    for (int i = 0; i < 3; i++) begin
      m_yrun[i] = (cur[i] == 2) ? m_yrun[i] + 1 : 0;
      m_prev[i] = cur[i];
    end
    m_allred = ar_next;
  endtask

  // Drive one cycle of inputs, clock it, then compare away from the edge.
  task automatic step(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                      input logic clr);
    L1 = a; L2 = b; L3 = c; Clear = clr;
    @(posedge Clock);
    model_clock(a, b, c, clr);
    #1;
    check_outputs("step");
  endtask

  task automatic run(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                     input int n);
    for (int k = 0; k < n; k++) step(a, b, c, 1'b0);
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must drop without a clock edge.
  task automatic pulse_reset();
    #2;
    Reset = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    check_eq("rst_async_zero", int'({Fault, FaultCode, FaultLamp}), 0);
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  initial begin
    logic [1:0] cur[3];
    logic       clr;
    int         r;
    n_vec = 0;
    n_err = 0;
    model_reset();
    Reset = 1'b0; Clear = 1'b0; L1 = R; L2 = R; L3 = R;
    #12;
    check_outputs("reset");
    Reset = 1'b1;

    // Legal full phase cycle, twice.
    for (int rep = 0; rep < 2; rep++) begin
      run(G, R, R, 45);
      run(Y, R, R, 5);
      run(R, R, R, 1);
      run(R, G, G, 15);
      run(R, Y, Y, 5);
      run(R, R, R, 1);
    end
    check_eq("legal_cycle_fault", int'(Fault), 0);

    // Clear is ignored while armed.
    step(R, R, R, 1'b1);
    check_eq("clear_armed", int'(Fault), 0);

    // Conflict L1/L2 green.
    step(G, G, R, 1'b0);
    check_eq("conflict_code", int'(FaultCode), 2);
    check_eq("conflict_lamp", int'(FaultLamp), 3);
    step(R, R, R, 1'b1);
    check_eq("conflict_clear", int'(Fault), 0);
    step(R, R, R, 1'b0);

    // Short yellow on L1.
    run(G, R, R, 3);
    run(Y, R, R, 3);
    step(R, R, R, 1'b0);
    check_eq("short_yel_code", int'(FaultCode), 4);
    check_eq("short_yel_lamp", int'(FaultLamp), 1);
    step(R, R, R, 1'b1);
    check_eq("short_yel_clear", int'(Fault), 0);
    step(R, R, R, 1'b0);

    // Invalid L3 beats illegal L2 green->red; later violations ignored.
    run(R, G, R, 3);
    step(R, R, X, 1'b0);
    check_eq("invalid_code", int'(FaultCode), 1);
    check_eq("invalid_lamp", int'(FaultLamp), 4);
    step(G, G, X, 1'b0);
    step(Y, G, G, 1'b0);
    check_eq("held_code", int'(FaultCode), 1);
    check_eq("held_lamp", int'(FaultLamp), 4);
    step(R, R, R, 1'b1);
    step(R, R, R, 1'b0);

    // All red for nine cycles.
    run(G, R, R, 2);
    run(Y, R, R, 5);
    run(R, R, R, 9);
    check_eq("watchdog_fault", int'(Fault), WdFault);
    check_eq("watchdog_code", int'(FaultCode), WdCode);

    // Reset while faulted, then red->yellow on the first cycle is not checked.
    step(G, G, R, 1'b0);
    check_eq("pre_reset_fault", int'(Fault), 1);
    pulse_reset();
    step(Y, R, R, 1'b0);
    step(Y, R, R, 1'b0);
    check_eq("post_reset_ry", int'(Fault), 0);
    run(Y, R, R, 3);
    run(R, R, R, 1);

    // Randomized lamp evolution with occasional glitches, clears and resets.
    cur[0] = R; cur[1] = R; cur[2] = R;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 3; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 3) begin
          cur[i] = 2'($urandom_range(0, 3));
        end else if (r < 15) begin
          case (cur[i])
            R:       cur[i] = G;
            G:       cur[i] = Y;
            default: cur[i] = R;
          endcase
        end
      end
      clr = ($urandom_range(0, 99) < 15);
      step(cur[0], cur[1], cur[2], clr);
      if (n % 500 == 499) pulse_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/light_monitor.md
LIGHT_MONITOR -- requirements
Module: light_monitor

Interface
REQ-001 SHALL have parameter: YEL_MIN, 5, minimum legal yellow duration in clock cycles (1..255).
REQ-002 SHALL have parameter: ALLRED_MAX, 8, maximum legal all-red duration in cycles (watchdog build only, 1..255).
REQ-003 SHALL have port: Clock  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port: Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: L1  input  2  NB SW 4th Ave light code (11 red, 01 green, 10 yellow, 00 invalid).
REQ-006 SHALL have port: L2  input  2  EB SW Harrison St light code, same encoding.
REQ-007 SHALL have port: L3  input  2  WB SW Harrison St light code, same encoding.
REQ-008 SHALL have port: Clear  input  1  fault acknowledge, level-sampled.
REQ-009 SHALL have port: Fault  output  1  latched fault / failsafe request, registered.
REQ-010 SHALL have port: FaultCode  output  3  cause of latched fault, registered.
REQ-011 SHALL have port: FaultLamp  output  3  one-hot lamp(s) implicated (bit0 L1, bit1 L2, bit2 L3), registered.

Function
REQ-012 SHALL implement states MON_INIT, MON_ARMED, MON_FAULT.
REQ-013 MON_INIT SHALL capture L1..L3 as previous codes, perform no checks, go to MON_ARMED next cycle.
REQ-014 MON_ARMED SHALL check every cycle: invalid code 00 on any lamp (code 1); conflict, L1 non-red while L2 or L3 non-red (code 2); illegal transition green->red, red->yellow, yellow->green (code 3); yellow->red with yellow count < YEL_MIN (code 4); watchdog (code 5, REQ-024).
REQ-015 Each lamp SHALL keep an 8-bit yellow counter: loads 1 on first yellow cycle, increments while yellow, saturates at 255, clears on non-yellow.
REQ-016 Simultaneous violations SHALL report lowest code number; FaultLamp SHALL flag every lamp implicated in the reported code (conflict: L1 plus offending Harrison lamp(s)).
REQ-017 On any violation in MON_ARMED: next cycle Fault=1, FaultCode/FaultLamp loaded, state MON_FAULT (latency one cycle).
REQ-018 MON_FAULT SHALL hold Fault, FaultCode, FaultLamp constant and ignore further violations.
REQ-019 Clear=1 in MON_FAULT SHALL next cycle set Fault=0, FaultCode=0, FaultLamp=0, state MON_INIT; Clear SHALL be ignored in MON_INIT and MON_ARMED.
REQ-020 Clear in MON_FAULT concurrent with a new violation SHALL return to MON_INIT (Clear wins).
REQ-021 Unchanged lamp code or green->yellow, yellow->red, red->green SHALL be legal transitions.

Reset
REQ-022 Reset=0 SHALL immediately force state MON_INIT, Fault=0, FaultCode=0, FaultLamp=0, yellow counters 0, previous codes 11 (red).
REQ-023 Reset asserted mid-fault or mid-yellow SHALL discard all history; first post-reset cycle is MON_INIT.

Configuration
REQ-024 With LIGHT_MONITOR_WATCHDOG_EN defined, an 8-bit all-red counter SHALL increment while all three lamps are 11 (saturating), clear otherwise, and flag code 5 when it exceeds ALLRED_MAX.
REQ-025 Without LIGHT_MONITOR_WATCHDOG_EN, the all-red counter SHALL not exist and code 5 SHALL never be reported; ALLRED_MAX is unused.

Structure
REQ-026 Shared package tlc_pkg SHALL hold light-code typedef (RED, GREEN, YELLOW, OFF), monitor-state enum, fault-code enum (NONE=0..WATCHDOG=5).
REQ-027 Sub-module lamp_tracker SHALL be instantiated three times, each holding previous code, yellow counter, and producing invalid/illegal-transition/short-yellow flags.

Verification
REQ-028 Legal cycle (L1 green 45, yellow 5, all red 1, L2/L3 green 15, yellow 5, all red 1), repeated twice -> Fault stays 0.
REQ-029 L1=01 and L2=01 in same cycle -> next cycle Fault=1, FaultCode=2, FaultLamp=011.
REQ-030 L1 yellow 3 cycles then red, YEL_MIN=5 -> FaultCode=4, FaultLamp=001; pulse Clear -> Fault=0 next cycle, then MON_INIT.
REQ-031 L3 00 and L2 green->red same cycle -> FaultCode=1, FaultLamp=100; later violations while faulted leave outputs unchanged.
REQ-032 Watchdog build, all red for 9 cycles, ALLRED_MAX=8 -> FaultCode=5; non-watchdog build, same stimulus -> Fault=0.
REQ-033 Reset pulsed low while Fault=1 -> outputs 0 immediately; after release, L1 red->yellow on first cycle not flagged (MON_INIT).
